// File: rtl/ram_access_ctrl_if.sv
// Bundle of the CPU load/store port, the program-loader port and the RAM pins
// seen by the RAM access controller.
interface ram_access_ctrl_if #(
  parameter int unsigned ADDR_W = 14
);
  // CPU load/store port
  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_size;
  logic              cpu_unsigned;
  logic [ADDR_W+1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ack;
  logic              cpu_err;
  // UART program loader port
  logic              ldr_req;
  logic [ADDR_W-1:0] ldr_addr;
  logic [31:0]       ldr_wdata;
  logic              ldr_ack;
  // Single-port word RAM
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout;

  // Controller side
  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_addr, ldr_wdata, ram_dout,
    output cpu_rdata, cpu_ack, cpu_err, ldr_ack, ram_addr, ram_din, ram_we
  );

  // Requester / RAM side
  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    output ldr_req, ldr_addr, ldr_wdata, ram_dout,
    input  cpu_rdata, cpu_ack, cpu_err, ldr_ack, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// RAM access controller: arbitrates loader vs CPU onto a single-port word RAM,
// turns byte/half stores into read-modify-write and extracts/extends sub-word loads.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_access_ctrl_if.slave  bus
);

  localparam int unsigned BA_W    = ADDR_W + 2;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [1:0]  SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {IDLE, LDR_WR, CPU_RD, RMW_RD, CPU_WR, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              blank_ldr_q, blank_ldr_d;
  logic              blank_cpu_q, blank_cpu_d;

  logic              misaligned_c;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;
  logic [31:0]       lane_mask;
  logic [31:0]       merged;

  // Alignment check on the live CPU request, used only at grant
  assign misaligned_c = (bus.cpu_size == SZ_BAD)
                      | ((bus.cpu_size == SZ_HALF) & bus.cpu_addr[0])
                      | ((bus.cpu_size == SZ_WORD) & (|bus.cpu_addr[1:0]));

  // Addressed byte/half of the RAM word for loads
  assign ld_byte = 8'(bus.ram_dout >> {lane_q, 3'b000});
  assign ld_half = 16'(bus.ram_dout >> {lane_q[1], 4'b0000});

  // Load result: sign/zero extension of the extracted lane, word passes through
  always_comb begin
    ld_val = bus.ram_dout;
    case (size_q)
      SZ_BYTE: ld_val = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
      SZ_HALF: ld_val = {{16{ld_half[15] & ~uns_q}}, ld_half};
      default: ld_val = bus.ram_dout;
    endcase
  end

  // Store merge: replace the addressed lane(s) of the old word with the store data
  always_comb begin
    lane_mask = 32'h0000_FFFF;
    if (size_q == SZ_BYTE) lane_mask = 32'h0000_00FF;
    lane_mask = lane_mask << {lane_q, 3'b000};
    merged    = (bus.ram_dout & ~lane_mask) | ((din_q << {lane_q, 3'b000}) & lane_mask);
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    din_d       = din_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    blank_ldr_d = (state_q == LDR_WR);
    blank_cpu_d = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (bus.ldr_req && !blank_ldr_q) begin
          state_d = LDR_WR;
          addr_d  = bus.ldr_addr;
          din_d   = bus.ldr_wdata;
        end else if (bus.cpu_req && !blank_cpu_q) begin
          addr_d = bus.cpu_addr[BA_W-1:2];
          lane_d = bus.cpu_addr[1:0];
          size_d = bus.cpu_size;
          uns_d  = bus.cpu_unsigned;
          err_d  = misaligned_c;
          if (misaligned_c) begin
            state_d = DONE;
            rdata_d = '0;
          end else if (!bus.cpu_we) begin
            state_d = CPU_RD;
          end else begin
            din_d   = bus.cpu_wdata;
            state_d = (bus.cpu_size == SZ_WORD) ? CPU_WR : RMW_RD;
          end
        end
      end
      LDR_WR: state_d = IDLE;
      CPU_RD: begin
        rdata_d = ld_val;
        state_d = DONE;
      end
      RMW_RD: begin
        din_d   = merged;
        state_d = CPU_WR;
      end
      CPU_WR: state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      din_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      blank_ldr_q <= 1'b0;
      blank_cpu_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      din_q       <= din_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      blank_ldr_q <= blank_ldr_d;
      blank_cpu_q <= blank_cpu_d;
    end
  end

  // Outputs come straight from registers or are decoded from the state register
  assign bus.ram_we    = (state_q == LDR_WR) || (state_q == CPU_WR);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = din_q;
  assign bus.ldr_ack   = (state_q == LDR_WR);
  assign bus.cpu_ack   = (state_q == DONE);
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_err   = err_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: owns the RAM array, predicts every write, ack,
// load result and error from a byte-level memory model and a per-cycle schedule.
module tb_ram_access_ctrl;

  localparam int unsigned AW    = 14;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_exp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } cpu_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] ram       [DEPTH];
  logic [31:0] mem_model [DEPTH];
  logic [31:0] last_rdata;

  wr_exp_t  exp_we  [int];
  cpu_exp_t exp_cpu [int];
  bit       exp_ldr [int];

  ram_access_ctrl_if #(.ADDR_W(AW)) bus ();

  ram_access_ctrl #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bench-owned RAM: combinational read, write on posedge
  assign bus.ram_dout = ram[bus.ram_addr];
  always @(posedge clk) if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_misaligned(input logic [1:0] size, input logic [15:0] addr);
    int a;
    a = int'(addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return (a % 2) != 0;
    if (size == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic int model_bytes(input logic [1:0] size);
    if (size == 2'd0) return 1;
    if (size == 2'd1) return 2;
    return 4;
  endfunction

  // Load: gather n bytes little-endian, then sign-extend by subtracting 2^(8n)
  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] lo,
                                             input logic [1:0] size, input logic uns);
    int n;
    logic [31:0] v;
    n = model_bytes(size);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | ((32'(word >> (8 * (int'(lo) + k))) & 32'hFF) << (8 * k));
    if (n < 4 && !uns && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // Store: overwrite n byte lanes starting at lane lo
  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] lo,
                                              input logic [1:0] size, input logic [31:0] wdata);
    int n;
    logic [31:0] r;
    n = model_bytes(size);
    r = old;
    for (int k = 0; k < n; k++) r[(int'(lo) + k) * 8 +: 8] = wdata[k * 8 +: 8];
    return r;
  endfunction

  // Per-cycle compare of DUT outputs against the predicted schedule
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("ram_we", 32'(bus.ram_we), 32'(exp_we.exists(cyc)));
      if (bus.ram_we === 1'b1 && exp_we.exists(cyc)) begin
        chk("ram_addr", 32'(bus.ram_addr), 32'(exp_we[cyc].addr));
        chk("ram_din", bus.ram_din, exp_we[cyc].data);
      end
      chk("cpu_ack", 32'(bus.cpu_ack), 32'(exp_cpu.exists(cyc)));
      if (bus.cpu_ack === 1'b1 && exp_cpu.exists(cyc)) begin
        chk("cpu_rdata", bus.cpu_rdata, exp_cpu[cyc].rdata);
        chk("cpu_err", 32'(bus.cpu_err), 32'(exp_cpu[cyc].err));
      end
      chk("ldr_ack", 32'(bus.ldr_ack), 32'(exp_ldr.exists(cyc)));
    end
  end

  // Loader word write; start = cycles until grant, hold = extra cycles req stays up after ack
  task automatic ldr_op(input logic [AW-1:0] addr, input logic [31:0] data,
                        input int start, input int hold);
    int g;
    int n;
    wr_exp_t w;
    g = cyc + start;
    mem_model[addr] = data;
    w.addr = addr;
    w.data = data;
    exp_we[g + 1]  = w;
    exp_ldr[g + 1] = 1'b1;
    bus.ldr_addr  = addr;
    bus.ldr_wdata = data;
    bus.ldr_req   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ldr_ack !== 1'b1 && n < 30);
    chk("ldr_ack_seen", 32'(bus.ldr_ack), 32'd1);
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    bus.ldr_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // CPU access; returns the cpu_rdata seen with the ack
  task automatic cpu_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        input int start, input int hold, output logic [31:0] got);
    int g;
    int lat;
    int n;
    logic [AW-1:0] wa;
    cpu_exp_t e;
    wr_exp_t w;
    g  = cyc + start;
    wa = addr[AW+1:2];
    e.err = 1'b0;
    if (model_misaligned(size, addr)) begin
      lat = 1;
      e.err = 1'b1;
      last_rdata = 32'd0;
    end else if (!we) begin
      lat = 2;
      last_rdata = model_load(mem_model[wa], addr[1:0], size, uns);
    end else begin
      lat = (size == 2'd2) ? 2 : 3;
      mem_model[wa] = model_store(mem_model[wa], addr[1:0], size, wdata);
      w.addr = wa;
      w.data = mem_model[wa];
      exp_we[g + lat - 1] = w;
    end
    e.rdata = last_rdata;
    exp_cpu[g + lat] = e;
    bus.cpu_we       = we;
    bus.cpu_size     = size;
    bus.cpu_unsigned = uns;
    bus.cpu_addr     = addr;
    bus.cpu_wdata    = wdata;
    bus.cpu_req      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.cpu_ack !== 1'b1 && n < 30);
    chk("cpu_ack_seen", 32'(bus.cpu_ack), 32'd1);
    got = bus.cpu_rdata;
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'd0);
    chk({tag, "_cpu_err"}, 32'(bus.cpu_err), 32'd0);
    chk({tag, "_cpu_ack"}, 32'(bus.cpu_ack), 32'd0);
    chk({tag, "_ldr_ack"}, 32'(bus.ldr_ack), 32'd0);
    chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
    chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    chk({tag, "_ram_din"}, bus.ram_din, 32'd0);
  endtask

  logic [31:0] got;
  logic [31:0] got2;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 32'd0;
      mem_model[i] = 32'd0;
    end
    last_rdata       = 32'd0;
    bus.cpu_req      = 1'b0;
    bus.cpu_we       = 1'b0;
    bus.cpu_size     = 2'd0;
    bus.cpu_unsigned = 1'b0;
    bus.cpu_addr     = '0;
    bus.cpu_wdata    = '0;
    bus.ldr_req      = 1'b0;
    bus.ldr_addr     = '0;
    bus.ldr_wdata    = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Loader write then word load
    ldr_op(14'd5, 32'h1122_3344, 0, 0);
    chk("ram5_after_ldr", ram[5], 32'h1122_3344);
    cpu_op(1'b0, 2'd2, 1'b0, 16'h0014, 32'd0, 0, 0, got);
    chk("lw_0x14", got, 32'h1122_3344);

    // Byte store and byte loads
    cpu_op(1'b1, 2'd0, 1'b0, 16'h0015, 32'h0000_00AB, 0, 0, got);
    chk("ram5_after_sb", ram[5], 32'h1122_AB44);
    cpu_op(1'b0, 2'd0, 1'b0, 16'h0015, 32'd0, 0, 0, got);
    chk("lb_0x15", got, 32'hFFFF_FFAB);
    cpu_op(1'b0, 2'd0, 1'b1, 16'h0015, 32'd0, 0, 0, got);
    chk("lbu_0x15", got, 32'h0000_00AB);

    // Half store and half loads
    cpu_op(1'b1, 2'd1, 1'b0, 16'h0016, 32'h0000_8001, 0, 0, got);
    chk("ram5_after_sh", ram[5], 32'h8001_AB44);
    cpu_op(1'b0, 2'd1, 1'b0, 16'h0016, 32'd0, 0, 0, got);
    chk("lh_0x16", got, 32'hFFFF_8001);
    cpu_op(1'b0, 2'd1, 1'b1, 16'h0016, 32'd0, 0, 0, got);
    chk("lhu_0x16", got, 32'h0000_8001);
    cpu_op(1'b0, 2'd0, 1'b0, 16'h0014, 32'd0, 0, 0, got);
    chk("lb_0x14", got, 32'h0000_0044);

    // Simultaneous requests: loader first, CPU granted two cycles later
    fork
      ldr_op(14'd9, 32'hCAFE_F00D, 0, 1);
      cpu_op(1'b0, 2'd2, 1'b0, 16'h0014, 32'd0, 2, 0, got2);
    join
    chk("lw_after_arb", got2, 32'h8001_AB44);
    chk("ram9_after_arb", ram[9], 32'hCAFE_F00D);
    cpu_op(1'b0, 2'd2, 1'b0, 16'h0024, 32'd0, 0, 1, got);
    chk("lw_0x24_hold", got, 32'hCAFE_F00D);

    // Word store / load
    cpu_op(1'b1, 2'd2, 1'b0, 16'h0020, 32'h55AA_1234, 0, 0, got);
    chk("ram8_after_sw", ram[8], 32'h55AA_1234);
    cpu_op(1'b0, 2'd2, 1'b0, 16'h0020, 32'd0, 0, 0, got);
    chk("lw_0x20", got, 32'h55AA_1234);

    // Misaligned and illegal accesses
    cpu_op(1'b0, 2'd2, 1'b0, 16'h0013, 32'd0, 0, 0, got);
    chk("lw_0x13_rdata", got, 32'd0);
    cpu_op(1'b0, 2'd3, 1'b0, 16'h0010, 32'd0, 0, 0, got);
    chk("size11_rdata", got, 32'd0);
    cpu_op(1'b1, 2'd1, 1'b0, 16'h0021, 32'h0000_BEEF, 0, 0, got);
    chk("ram8_after_bad_sh", ram[8], 32'h55AA_1234);

    // Reset while the byte store is in its read phase
    bus.cpu_we       = 1'b1;
    bus.cpu_size     = 2'd0;
    bus.cpu_unsigned = 1'b0;
    bus.cpu_addr     = 16'h0015;
    bus.cpu_wdata    = 32'h0000_00EE;
    bus.cpu_req      = 1'b1;
    @(posedge clk); #1;
    rst_n       = 1'b0;
    bus.cpu_req = 1'b0;
    #1 chk_all_zero("midreset");
    repeat (2) begin
      @(negedge clk);
      chk("ram_we_in_reset", 32'(bus.ram_we), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_rdata = 32'd0;
    @(posedge clk); #1;
    chk("ram5_after_abort", ram[5], 32'h8001_AB44);
    cpu_op(1'b0, 2'd2, 1'b0, 16'h0014, 32'd0, 0, 0, got);
    chk("lw_after_abort", got, 32'h8001_AB44);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
